// File: rtl/tile_writer_pkg.sv
// tile_writer_pkg: shared font width, control codes and FSM state type for the tile writer.
package tile_writer_pkg;
    localparam int FONT_WIDTH = 8;
    localparam logic [FONT_WIDTH-1:0] CODE_BS = 8'h08;
    localparam logic [FONT_WIDTH-1:0] CODE_LF = 8'h0A;
    localparam logic [FONT_WIDTH-1:0] CODE_FF = 8'h0C;
    localparam logic [FONT_WIDTH-1:0] CODE_CR = 8'h0D;
    localparam logic [FONT_WIDTH-1:0] PRINT_LO = 8'h20;
    localparam logic [FONT_WIDTH-1:0] PRINT_HI = 8'h7E;
    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;
endpackage

// File: rtl/tile_cursor.sv
// tile_cursor: column/row cursor with wrap and a row*COLS+col tile address.
module tile_cursor
    import tile_writer_pkg::*;
#(
    parameter int COLS = 20,
    parameter int ROWS = 15
) (
    input  logic                          px_clk,
    input  logic                          rstn,
    input  logic                          home,
    input  logic                          inc,
    input  logic                          dec,
    input  logic                          cr,
    input  logic                          lf,
    output logic [$clog2(COLS)-1:0]       col,
    output logic [$clog2(ROWS)-1:0]       row,
    output logic [$clog2(COLS*ROWS)-1:0]  addr
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int AW = $clog2(COLS*ROWS);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          last_col;
    logic [RW-1:0] row_nx;

    assign last_col = col_q == CW'(COLS-1);
    assign row_nx   = (row_q == RW'(ROWS-1)) ? '0 : row_q + 1'b1;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (home) begin
            col_d = '0;
            row_d = '0;
        end else if (inc) begin
            col_d = last_col ? '0 : col_q + 1'b1;
            row_d = last_col ? row_nx : row_q;
        end else if (dec) begin
            col_d = (col_q == '0) ? col_q : col_q - 1'b1;
        end else if (cr) begin
            col_d = '0;
        end else if (lf) begin
            row_d = row_nx;
        end
    end

    always_ff @(posedge px_clk) begin
        if (!rstn) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col  = col_q;
    assign row  = row_q;
    assign addr = AW'(row_q) * AW'(COLS) + AW'(col_q);
endmodule

// File: rtl/tile_writer.sv
// tile_writer: turns a char stream into tile-memory writes with cursor control and screen clear.
module tile_writer
    import tile_writer_pkg::*;
#(
    parameter int COLS = 20,
    parameter int ROWS = 15,
    parameter logic [FONT_WIDTH-1:0] FILL = 8'h20
) (
    input  logic                          px_clk,
    input  logic                          rstn,
    input  logic                          char_valid,
    input  logic [FONT_WIDTH-1:0]         char_data,
    output logic                          char_ready,
    output logic                          wr_en,
    output logic [$clog2(COLS*ROWS)-1:0]  wr_addr,
    output logic [FONT_WIDTH-1:0]         wr_data,
    output logic [$clog2(COLS)-1:0]       cursor_col,
    output logic [$clog2(ROWS)-1:0]       cursor_row,
    output logic                          busy
);
    localparam int N  = COLS*ROWS;
    localparam int AW = $clog2(N);

    state_t                state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [AW-1:0]         wr_addr_q, wr_addr_d;
    logic [FONT_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [AW-1:0]         cur_addr;
    logic                  acc, prn, inc, dec, cr, lf, home;

    assign acc  = state_q == ST_IDLE && char_valid;
    assign prn  = char_data >= PRINT_LO && char_data <= PRINT_HI;
    assign inc  = acc && prn;
    assign dec  = acc && char_data == CODE_BS && cursor_col != '0;
    assign cr   = acc && char_data == CODE_CR;
    assign lf   = acc && char_data == CODE_LF;
    assign home = acc && char_data == CODE_FF;

    tile_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
        .px_clk (px_clk),
        .rstn   (rstn),
        .home   (home),
        .inc    (inc),
        .dec    (dec),
        .cr     (cr),
        .lf     (lf),
        .col    (cursor_col),
        .row    (cursor_row),
        .addr   (cur_addr)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en_d   = inc || dec;
        wr_addr_d = dec ? cur_addr - 1'b1 : cur_addr;
        wr_data_d = dec ? FILL : char_data;
        if (state_q == ST_CLEAR) begin
            // Leave only once the final fill write is already on the outputs.
            if (wr_en_q && wr_addr_q == AW'(N-1)) begin
                state_d = ST_IDLE;
                wr_en_d = 1'b0;
            end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = FILL;
                cnt_d     = (cnt_q == AW'(N-1)) ? '0 : cnt_q + 1'b1;
            end
        end else if (home) begin
            state_d = ST_CLEAR;
        end
    end

    always_ff @(posedge px_clk) begin
        if (!rstn) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= FILL;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign char_ready = state_q == ST_IDLE;
    assign busy       = state_q == ST_CLEAR;
endmodule

// File: tb/tb_tile_writer.sv
// tb_tile_writer: directed and random char streams checked cycle by cycle against a screen model.
module tb_tile_writer;
    localparam int COLS = 20;
    localparam int ROWS = 15;
    localparam int N    = COLS*ROWS;
    localparam logic [7:0] FILL = 8'h20;

    logic       px_clk = 1'b0;
    logic       rstn = 1'b0;
    logic       char_valid = 1'b0;
    logic [7:0] char_data = 8'h00;
    logic       char_ready, wr_en, busy;
    logic [8:0] wr_addr;
    logic [7:0] wr_data;
    logic [4:0] cursor_col;
    logic [3:0] cursor_row;

    int n_chk = 0;
    int n_pass = 0;

    int m_col = 0, m_row = 0, m_addr = 0, m_k = 0;
    logic m_wen = 1'b0, m_clr = 1'b1;
    logic [7:0] m_data = 8'h00;

    always #5 px_clk = ~px_clk;

    tile_writer #(.COLS(COLS), .ROWS(ROWS), .FILL(FILL)) dut (
        .px_clk     (px_clk),
        .rstn       (rstn),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic step(input logic rn, input logic v, input logic [7:0] d);
        rstn = rn;
        char_valid = v;
        char_data = d;
        @(posedge px_clk);
        if (!rn) begin
            m_wen = 1'b0; m_col = 0; m_row = 0; m_clr = 1'b1; m_k = 0;
        end else if (m_clr) begin
            if (m_k == N) begin
                m_clr = 1'b0; m_wen = 1'b0; m_k = 0;
            end else begin
                m_wen = 1'b1; m_addr = m_k; m_data = FILL; m_k++;
            end
        end else begin
            m_wen = 1'b0;
            if (v) begin
                if (d >= 8'h20 && d <= 8'h7E) begin
                    m_wen = 1'b1; m_addr = m_row*COLS + m_col; m_data = d;
                    m_col++;
                    if (m_col == COLS) begin
                        m_col = 0;
                        m_row = (m_row + 1) % ROWS;
                    end
                end else if (d == 8'h0D) begin
                    m_col = 0;
                end else if (d == 8'h0A) begin
                    m_row = (m_row + 1) % ROWS;
                end else if (d == 8'h08) begin
                    if (m_col > 0) begin
                        m_col--;
                        m_wen = 1'b1; m_addr = m_row*COLS + m_col; m_data = FILL;
                    end
                end else if (d == 8'h0C) begin
                    m_clr = 1'b1; m_k = 0; m_col = 0; m_row = 0;
                end
            end
        end
        #1;
        check("wr_en", 32'(wr_en), 32'(m_wen));
        if (m_wen) begin
            check("wr_addr", 32'(wr_addr), 32'(m_addr));
            check("wr_data", 32'(wr_data), 32'(m_data));
        end
        check("cursor_col", 32'(cursor_col), 32'(m_col));
        check("cursor_row", 32'(cursor_row), 32'(m_row));
        check("busy", 32'(busy), 32'(m_clr));
        check("char_ready", 32'(char_ready), 32'(!m_clr));
    endtask

    task automatic put(input logic [7:0] d);
        step(1'b1, 1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        int clr_writes;
        int guard;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
        clr_writes = 0;
        for (int i = 0; i < N + 1; i++) begin
            step(1'b1, 1'b0, 8'h00);
            if (wr_en === 1'b1) clr_writes++;
        end
        check("powerup_clear_count", 32'(clr_writes), 32'(N));
        idle(2);
        put(8'h41);
        idle(1);
        put(8'h0D);
        for (int i = 0; i < 21; i++) put(8'h30 + 8'(i));
        check("col_after_21", 32'(cursor_col), 32'd1);
        check("row_after_21", 32'(cursor_row), 32'd1);
        put(8'h0C);
        idle(N + 2);
        for (int i = 0; i < N - 1; i++) put(8'h21 + 8'(i % 90));
        put(8'h5A);
        check("wrap_addr", 32'(wr_addr), 32'd299);
        for (int i = 0; i < 3; i++) put(8'h0A);
        for (int i = 0; i < 5; i++) put(8'h61);
        put(8'h0D);
        put(8'h0A);
        put(8'h08);
        for (int i = 0; i < 3; i++) put(8'h62);
        put(8'h08);
        check("bs_addr", 32'(wr_addr), 32'd82);
        put(8'h7F);
        put(8'h1B);
        put(8'h0C);
        guard = 0;
        while (!(m_wen && m_addr == 100) && guard < 400) begin
            step(1'b1, 1'b0, 8'h00);
            guard++;
        end
        check("reach_clear_100", 32'(guard < 400), 32'd1);
        step(1'b0, 1'b0, 8'h00);
        clr_writes = 0;
        for (int i = 0; i < N + 1; i++) begin
            step(1'b1, 1'b1, 8'h41);
            if (wr_en === 1'b1) clr_writes++;
        end
        check("restart_clear_count", 32'(clr_writes), 32'(N));
        idle(1);
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [7:0] d;
            r = $urandom_range(0, 99);
            d = r < 60 ? 8'($urandom_range(32'h20, 32'h7E)) :
                r < 68 ? 8'h0D :
                r < 76 ? 8'h0A :
                r < 88 ? 8'h08 :
                r < 89 ? 8'h0C :
                r < 94 ? 8'($urandom_range(0, 31)) : 8'($urandom_range(32'h7F, 32'hFF));
            step($urandom_range(0, 999) != 0, $urandom_range(0, 9) < 7, d);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
